// File: rtl/slave_regfile_pkg.sv
// Shared defaults and register map for the traffic-light SPI register file.
package slave_regfile_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 2;
  localparam int DEF_NUM_REGS = 4;

  typedef enum logic [DEF_ADDR_W-1:0] {
    A_T_R_WAIT = 2'd0,
    A_T_G_WAIT = 2'd1,
    A_T_Y_WAIT = 2'd2,
    A_MODE     = 2'd3
  } reg_addr_e;

endpackage

// File: rtl/slave_regfile_param_sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff (
  input  logic spi_sclk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic sync1;

  always_ff @(posedge spi_sclk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= 1'b0;
      q     <= 1'b0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/slave_regfile_param.sv
// SPI-side configuration register file: pipelined writes with done/dirty
// reporting, and core-domain reads through a synchronised req/ack handshake.
module slave_regfile_param
  import slave_regfile_pkg::*;
#(
  parameter int                NUM_REGS = DEF_NUM_REGS,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                spi_sclk,
  input  logic                n_rst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                wen,
  input  logic [DATA_W-1:0]   data,
  input  logic                r_en,
  input  logic [ADDR_W-1:0]   r_addr,
  input  logic                done_sync2,
  output logic [DATA_W-1:0]   r_data,
  output logic                r_err,
  output logic                ren_ack,
  output logic                done,
  output logic [NUM_REGS-1:0] dirty,
  output logic                wr_err
);

  localparam logic [ADDR_W:0] NUM_REGS_L = NUM_REGS[ADDR_W:0];

  logic [ADDR_W-1:0]   addr_d;
  logic                wen_d;
  logic [DATA_W-1:0]   data_d;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                ren_sync2;
  logic                ren_sync3;
  logic                wr_in_range;
  logic                rd_in_range;
  logic                commit;
  logic                rd_rise;
  logic [NUM_REGS-1:0] wr_mask;
  logic [DATA_W-1:0]   rd_val;

  assign wr_in_range = ({1'b0, addr_d} < NUM_REGS_L);
  assign rd_in_range = ({1'b0, r_addr} < NUM_REGS_L);
  assign commit      = wen_d & wr_in_range;
  assign rd_rise     = ren_sync2 & ~ren_sync3;

  // Out-of-range read addresses fall through the mux as zero.
  always_comb begin
    wr_mask = '0;
    rd_val  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit && (addr_d == ADDR_W'(i))) wr_mask[i] = 1'b1;
      if (r_addr == ADDR_W'(i))             rd_val     = regs[i];
    end
  end

  always_ff @(posedge spi_sclk or negedge n_rst) begin
    if (!n_rst) begin
      addr_d <= '0;
      wen_d  <= 1'b0;
      data_d <= '0;
    end else begin
      addr_d <= addr;
      wen_d  <= wen;
      data_d <= data;
    end
  end

  always_ff @(posedge spi_sclk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_mask[i]) regs[i] <= data_d;
      end
    end
  end

  // A commit beats a same-cycle acknowledge: only the fresh write stays dirty.
  always_ff @(posedge spi_sclk or negedge n_rst) begin
    if (!n_rst) begin
      done   <= 1'b0;
      dirty  <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wen_d & ~wr_in_range;
      if (commit) begin
        done  <= 1'b1;
        dirty <= done_sync2 ? wr_mask : (dirty | wr_mask);
      end else if (done_sync2) begin
        done  <= 1'b0;
        dirty <= '0;
      end
    end
  end

  // Four-phase read: core raises r_en with r_addr stable; data/err are
  // captured once and valid while ren_ack=1; core drops r_en, ren_ack follows.
  sync_2ff u_ren_sync (
    .spi_sclk (spi_sclk),
    .n_rst    (n_rst),
    .d        (r_en),
    .q        (ren_sync2)
  );

  always_ff @(posedge spi_sclk or negedge n_rst) begin
    if (!n_rst) begin
      ren_sync3 <= 1'b0;
      ren_ack   <= 1'b0;
      r_data    <= '0;
      r_err     <= 1'b0;
    end else begin
      ren_sync3 <= ren_sync2;
      ren_ack   <= ren_sync2;
      if (rd_rise) begin
        r_data <= rd_in_range ? rd_val : '0;
        r_err  <= ~rd_in_range;
      end
    end
  end

endmodule
